// File: rtl/lexington_mem_pkg.sv
// -----------------------------------------------------------------------------
// lexington_mem_pkg
// Shared data-memory definitions: the LSU access-size encoding, the fixed
// byte-lane geometry of the data BRAM, and helpers that turn an access size
// into a byte count and a right-justified lane mask.
// -----------------------------------------------------------------------------
package lexington_mem_pkg;

  localparam int NUM_COL   = 4;
  localparam int COL_WIDTH = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } mem_size_t;

  // Byte count of an access; 0 marks the illegal encoding.
  function automatic logic [2:0] size_to_bytes(input mem_size_t size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  // Lane mask for an access starting at lane 0.
  function automatic logic [NUM_COL-1:0] bytes_to_lanes(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Combinational load-data formatter. Joins the low and high BRAM words of an
// access, rotates the addressed bytes down to bit 0, keeps nbytes bytes and
// sign- or zero-extends the result to a full word.
//   lo_word      in   word holding the first addressed byte
//   hi_word      in   following word (only contributes when the access splits)
//   off          in   byte offset of the access within lo_word
//   nbytes       in   access length in bytes (1, 2 or 4)
//   is_unsigned  in   1 = zero-extend, 0 = sign-extend
//   rdata        out  formatted load data
// -----------------------------------------------------------------------------
module dmem_load_align
  import lexington_mem_pkg::*;
(
  input  logic [NUM_COL*COL_WIDTH-1:0] lo_word,
  input  logic [NUM_COL*COL_WIDTH-1:0] hi_word,
  input  logic [1:0]                   off,
  input  logic [2:0]                   nbytes,
  input  logic                         is_unsigned,
  output logic [NUM_COL*COL_WIDTH-1:0] rdata
);

  localparam int DW = NUM_COL * COL_WIDTH;

  logic [DW-1:0] shifted;
  logic          fill_b;
  logic          fill_h;

  // A left shift by the full word width yields zero, so an aligned access
  // (off = 0) takes lo_word unchanged and hi_word drops out.
  always_comb begin
    shifted = (lo_word >> (int'(off) * COL_WIDTH))
            | (hi_word << (DW - int'(off) * COL_WIDTH));
  end

  assign fill_b = ~is_unsigned & shifted[COL_WIDTH-1];
  assign fill_h = ~is_unsigned & shifted[2*COL_WIDTH-1];

  always_comb begin
    case (nbytes)
      3'd1:    rdata = {{(DW-COL_WIDTH){fill_b}}, shifted[COL_WIDTH-1:0]};
      3'd2:    rdata = {{(DW-2*COL_WIDTH){fill_h}}, shifted[2*COL_WIDTH-1:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_bram_port_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_bram_port_ctrl
// Initiator for one byte-write BRAM port (read-first, 1-cycle read latency).
// Converts single-outstanding LSU load/store requests into lane-enabled word
// accesses and returns extended load data.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we/addr/size/unsigned  store flag, byte address, size, load extension
//   req_wdata                  right-justified store data
//   rsp_valid/rsp_ready        response handshake, valid held until ready
//   rsp_rdata/rsp_err          extended load data (0 for stores/errors), error
//   mem_en/wen/addr/din/dout   BRAM port A
// Build option: define DMEM_MISALIGNED_EN to allow any alignment, splitting
// word-crossing accesses into two BRAM cycles. Without it, misaligned accesses
// return rsp_err with no BRAM access.
// -----------------------------------------------------------------------------
module dmem_bram_port_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_WIDTH+1:0]        req_addr,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  input  logic [NUM_COL*COL_WIDTH-1:0] req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [NUM_COL*COL_WIDTH-1:0] rsp_rdata,
  output logic                         rsp_err,
  output logic                         mem_en,
  output logic [NUM_COL-1:0]           mem_wen,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [NUM_COL*COL_WIDTH-1:0] mem_din,
  input  logic [NUM_COL*COL_WIDTH-1:0] mem_dout
);

  import lexington_mem_pkg::*;

  localparam int DW = NUM_COL * COL_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SECOND  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic                  uns_q, uns_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  split_q, split_d;
  logic [DW-1:0]         lo_buf_q, lo_buf_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DW-1:0]         rsp_rdata_q, rsp_rdata_d;

  // ---------------------------------------------------------------------------
  // Request decode (meaningful in IDLE only)
  // ---------------------------------------------------------------------------
  logic [1:0] req_off;
  logic [2:0] req_nbytes;
  logic       req_misalign;
  logic       req_err;
  logic       req_cross;

  assign req_off    = req_addr[1:0];
  assign req_nbytes = size_to_bytes(mem_size_t'(req_size));

`ifdef DMEM_MISALIGNED_EN
  assign req_misalign = 1'b0;
`else
  // nbytes-1 as a 2-bit mask: 0 for bytes, 1 for halves, 3 for words.
  assign req_misalign = (req_off & (req_nbytes[1:0] - 2'd1)) != 2'd0;
`endif

  assign req_err   = (req_nbytes == 3'd0) || req_misalign;
  assign req_cross = ({2'b00, req_off} + {1'b0, req_nbytes}) > 4'd4;

  // ---------------------------------------------------------------------------
  // Lane placement. The access is laid out over two adjacent words: the low
  // half of each double-width vector is the first word, the high half the
  // second. IDLE places the live request, SECOND the latched one.
  // ---------------------------------------------------------------------------
  logic                   in_idle;
  logic [1:0]             off_sel;
  logic [2:0]             nbytes_sel;
  logic [DW-1:0]          wdata_sel;
  logic [2*NUM_COL-1:0]   span;
  logic [2*DW-1:0]        din_pair;

  assign in_idle    = (state_q == ST_IDLE);
  assign off_sel    = in_idle ? req_off    : off_q;
  assign nbytes_sel = in_idle ? req_nbytes : nbytes_q;
  assign wdata_sel  = in_idle ? req_wdata  : wdata_q;
  assign span       = {{NUM_COL{1'b0}}, bytes_to_lanes(nbytes_sel)} << off_sel;
  assign din_pair   = {{DW{1'b0}}, wdata_sel} << (int'(off_sel) * COL_WIDTH);

  // ---------------------------------------------------------------------------
  // Load formatting: a split load joins the buffered first word with the
  // second word arriving now; an unsplit load sees the same word twice.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] align_lo;
  logic [DW-1:0] align_rdata;

  assign align_lo = split_q ? lo_buf_q : mem_dout;

  dmem_load_align u_align (
    .lo_word     (align_lo),
    .hi_word     (mem_dout),
    .off         (off_q),
    .nbytes      (nbytes_q),
    .is_unsigned (uns_q),
    .rdata       (align_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next state, BRAM drive and response
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    we_d        = we_q;
    word_d      = word_q;
    off_d       = off_q;
    nbytes_d    = nbytes_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    split_d     = split_q;
    lo_buf_d    = lo_buf_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = 1'b0;
    mem_en      = 1'b0;
    mem_wen     = '0;
    mem_addr    = req_addr[ADDR_WIDTH+1:2];
    mem_din     = din_pair[DW-1:0];

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          word_d   = req_addr[ADDR_WIDTH+1:2];
          off_d    = req_off;
          nbytes_d = req_nbytes;
          uns_d    = req_unsigned;
          wdata_d  = req_wdata;
          split_d  = req_cross;
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = ST_RESP;
          end else begin
            mem_en  = 1'b1;
            mem_wen = req_we ? span[NUM_COL-1:0] : '0;
            state_d = req_cross ? ST_SECOND : ST_CAPTURE;
          end
        end
      end

      ST_SECOND: begin
        mem_en   = 1'b1;
        mem_addr = word_q + ADDR_WIDTH'(1);
        mem_wen  = we_q ? span[2*NUM_COL-1:NUM_COL] : '0;
        mem_din  = din_pair[2*DW-1:DW];
        lo_buf_d = mem_dout;
        state_d  = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        rsp_rdata_d = we_q ? '0 : align_rdata;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      default: begin // ST_RESP
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      word_q      <= '0;
      off_q       <= '0;
      nbytes_q    <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      split_q     <= 1'b0;
      lo_buf_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      word_q      <= word_d;
      off_q       <= off_d;
      nbytes_q    <= nbytes_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      split_q     <= split_d;
      lo_buf_q    <= lo_buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_bram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_bram_port_ctrl
// Drives directed and random load/store requests into dmem_bram_port_ctrl,
// attached to a behavioural byte-write BRAM. Expected responses, BRAM
// strobes and latencies come from a byte-addressed reference memory and the
// access rules (size, alignment, word crossing). DMEM_MISALIGNED_EN selects
// which alignment rules are expected.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_bram_port_ctrl;

  localparam int AW        = 10;
  localparam int MEM_BYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_bram_port_ctrl #(.ADDR_WIDTH(AW), .NUM_COL(4), .COL_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  // Behavioural BRAM: read-first, one-cycle read latency, byte write enables.
  logic [31:0] bram [1 << AW];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= bram[mem_addr];
      for (int l = 0; l < 4; l++)
        if (mem_wen[l]) bram[mem_addr][8*l +: 8] <= mem_din[8*l +: 8];
    end
  end

  // Reference model: flat byte array.
  logic [7:0] ref_mem [MEM_BYTES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit expect_err(input logic [AW+1:0] addr, input logic [1:0] size);
    int n;
    n = size_bytes(size);
    if (n == 0) return 1'b1;
`ifdef DMEM_MISALIGNED_EN
    return 1'b0;
`else
    return (int'(addr) % n) != 0;
`endif
  endfunction

  function automatic logic [31:0] lanes_to_mask(input logic [3:0] w);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{w[l]}};
    return m;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete request/response transaction with full checking.
  task automatic do_req(input bit we, input logic [AW+1:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wdata, input int hold);
    int            n, b, lane, lat, exp_lat;
    bit            e, sp;
    logic [3:0]    w1, w2, l1, l2;
    logic [31:0]   d1, d2, exp_rd, held;
    logic [AW-1:0] a1, a2;

    n  = size_bytes(size);
    e  = expect_err(addr, size);
    sp = !e && ((int'(addr) % 4) + n > 4);
    a1 = addr[AW+1:2];
    a2 = a1 + AW'(1);
    w1 = '0; w2 = '0; l1 = '0; l2 = '0; d1 = '0; d2 = '0; exp_rd = '0;
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        b    = (int'(addr) + i) % MEM_BYTES;
        lane = b % 4;
        if ((b / 4) == int'(a1)) begin
          l1[lane] = 1'b1;
          d1[8*lane +: 8] = wdata[8*i +: 8];
        end else begin
          l2[lane] = 1'b1;
          d2[8*lane +: 8] = wdata[8*i +: 8];
        end
        if (!we) exp_rd[8*i +: 8] = ref_mem[b];
      end
      if (we) begin
        w1 = l1; w2 = l2;
        for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % MEM_BYTES] = wdata[8*i +: 8];
      end else if (!uns && n == 1) begin
        exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
      end else if (!uns && n == 2) begin
        exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
      end
    end
    exp_lat = e ? 1 : (sp ? 3 : 2);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    check("mem_en_first", 32'(mem_en), e ? 32'd0 : 32'd1);
    check("mem_wen_first", 32'(mem_wen), 32'(w1));
    if (!e) check("mem_addr_first", 32'(mem_addr), 32'(a1));
    if (!e && we) check("mem_din_first", mem_din & lanes_to_mask(w1), d1);
    @(posedge clk);
    #1;
    // Request fields are don't-care after acceptance.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = (AW+2)'($urandom);
    req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
    if (sp) begin
      check("mem_en_second", 32'(mem_en), 32'd1);
      check("mem_addr_second", 32'(mem_addr), 32'(a2));
      check("mem_wen_second", 32'(mem_wen), 32'(w2));
      if (we) check("mem_din_second", mem_din & lanes_to_mask(w2), d2);
      check("req_ready_second", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (!rsp_valid) begin
      apply_reset();
      return;
    end
    check("rsp_err", 32'(rsp_err), 32'(e));
    check("rsp_rdata", rsp_rdata, exp_rd);
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, held);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_mem_en", 32'(mem_en), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("req_ready_in_handshake", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW+1:0] a;
    for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store/load
    do_req(1'b1, 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    do_req(1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 0);
    // Byte store, signed and unsigned reloads
    do_req(1'b1, 12'h013, 2'd0, 1'b0, 32'h00000080, 0);
    do_req(1'b0, 12'h013, 2'd0, 1'b0, 32'h0, 0);
    do_req(1'b0, 12'h013, 2'd0, 1'b1, 32'h0, 0);
    // Word-crossing store/load (error without the misaligned build)
    do_req(1'b1, 12'h007, 2'd2, 1'b0, 32'h11223344, 0);
    do_req(1'b0, 12'h007, 2'd2, 1'b0, 32'h0, 0);
    // Misaligned half, illegal size load and store
    do_req(1'b0, 12'h001, 2'd1, 1'b0, 32'h0, 0);
    do_req(1'b0, 12'h010, 2'd3, 1'b0, 32'h0, 0);
    do_req(1'b1, 12'h020, 2'd3, 1'b0, 32'hCAFEF00D, 0);
    do_req(1'b0, 12'h020, 2'd2, 1'b0, 32'h0, 0);
    // Response held off for five cycles
    do_req(1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 5);
    // Top-of-memory load that wraps to word 0
    do_req(1'b1, 12'h000, 2'd2, 1'b0, 32'hA5A55A5A, 0);
    do_req(1'b1, 12'hFFC, 2'd2, 1'b0, 32'h7E6D5C4B, 0);
    do_req(1'b0, 12'hFFE, 2'd2, 1'b0, 32'h0, 0);

    // Reset while the same wrapping load is in flight
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'hFFE; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`ifdef DMEM_MISALIGNED_EN
    check("wrap_mem_en", 32'(mem_en), 32'd1);
    check("wrap_mem_addr", 32'(mem_addr), 32'd0);
`endif
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_err", 32'(rsp_err), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    check("midrst_mem_wen", 32'(mem_wen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);

    // Random traffic, concentrated on a small window plus the top of memory
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 9) < 7) a = (AW+2)'($urandom_range(0, 47));
      else a = (AW+2)'($urandom_range(MEM_BYTES - 8, MEM_BYTES - 1));
      do_req(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
